cv32e40p_tmr_voter_monitor: RTL and testbench

CV32E40P_TMR_VOTER_MONITOR -- requirements
Module: cv32e40p_tmr_voter_monitor

---
 rtl/cv32e40p_pkg.sv | 25 ++
 rtl/cv32e40p_voter_channel.sv | 163 ++++++++++++++++
 rtl/cv32e40p_tmr_voter_monitor.sv | 56 +++++
 tb/tb_cv32e40p_tmr_voter_monitor.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared types for the TMR voter monitor: per-channel health states and replica ids.
package cv32e40p_pkg;

    typedef enum logic [1:0] {
        NOMINAL  = 2'd0,
        SUSPECT  = 2'd1,
        ISOLATED = 2'd2,
        FAILED   = 2'd3
    } voter_state_e;

    localparam logic [1:0] REPLICA_NONE = 2'd0;
    localparam logic [1:0] REPLICA_1    = 2'd1;
    localparam logic [1:0] REPLICA_2    = 2'd2;
    localparam logic [1:0] REPLICA_3    = 2'd3;

    function automatic logic [2:0] replica_onehot(input logic [1:0] id);
        case (id)
            REPLICA_1: return 3'b001;
            REPLICA_2: return 3'b010;
            REPLICA_3: return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/cv32e40p_voter_channel.sv
// One TMR triplet: word vote, saturating error counter and (with CV32E40P_VOTER_ISOLATION_EN)
// the health FSM that isolates a persistently wrong replica.
module cv32e40p_voter_channel
    import cv32e40p_pkg::*;
#(
    parameter int unsigned LEN          = 32,
    parameter int unsigned ERR_CNT_W    = 8,
    parameter int unsigned FAULT_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic                 clr_i,
    input  logic [LEN-1:0]       in_1_i,
    input  logic [LEN-1:0]       in_2_i,
    input  logic [LEN-1:0]       in_3_i,
    output logic [LEN-1:0]       voted_o,
    output logic                 error_correct_o,
    output logic                 error_detected_o,
    output logic [2:0]           faulty_o,
    output logic                 failed_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    if (FAULT_THRESH < 1 || FAULT_THRESH > 15) begin : g_bad_thresh
        $error("FAULT_THRESH must be in 1..15");
    end

    logic                 w_eq12, w_eq13, w_eq23;
    logic [2:0]           w_iso;
    logic [LEN-1:0]       w_voted;
    logic                 w_corr, w_det;
    logic [LEN-1:0]       r_voted;
    logic                 r_corr, r_det;
    logic [ERR_CNT_W-1:0] r_cnt;

    assign w_eq12 = (in_1_i == in_2_i);
    assign w_eq13 = (in_1_i == in_3_i);
    assign w_eq23 = (in_2_i == in_3_i);

    // An isolated replica reduces the vote to a compare of the two survivors.
    always_comb begin
        w_voted = in_1_i;
        w_corr  = 1'b0;
        w_det   = 1'b0;
        case (w_iso)
            3'b001: begin
                w_voted = in_2_i;
                w_det   = !w_eq23;
            end
            3'b010:  w_det = !w_eq13;
            3'b100:  w_det = !w_eq12;
            default: begin
                if (!w_eq12 && !w_eq13 && w_eq23) w_voted = in_2_i;
                if (!(w_eq12 && w_eq13)) begin
                    w_det  = 1'b1;
                    w_corr = w_eq12 | w_eq13 | w_eq23;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_voted <= '0;
            r_corr  <= 1'b0;
            r_det   <= 1'b0;
        end else begin
            if (valid_i) r_voted <= w_voted;
            r_corr <= valid_i & w_corr;
            r_det  <= valid_i & w_det;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            r_cnt <= '0;
        end else if (valid_i && w_det && (r_cnt != '1)) begin
            r_cnt <= r_cnt + ERR_CNT_W'(1);
        end
    end

    assign voted_o          = r_voted;
    assign error_correct_o  = r_corr;
    assign error_detected_o = r_det;
    assign err_cnt_o        = r_cnt;

`ifdef CV32E40P_VOTER_ISOLATION_EN
    localparam logic [3:0] THRESH = 4'(FAULT_THRESH);

    voter_state_e r_state;
    logic [1:0]   r_suspect;
    logic [3:0]   r_streak;
    logic [2:0]   r_faulty;
    logic [1:0]   w_suspect;
    logic         w_uncorr;

    assign w_iso     = r_faulty;
    assign w_uncorr  = w_det & ~w_corr;
    assign w_suspect = w_eq12 ? REPLICA_3 : (w_eq13 ? REPLICA_2 : REPLICA_1);

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            r_state   <= NOMINAL;
            r_suspect <= REPLICA_NONE;
            r_streak  <= '0;
            r_faulty  <= '0;
        end else if (valid_i) begin
            case (r_state)
                NOMINAL: begin
                    if (w_uncorr) begin
                        r_state <= FAILED;
                    end else if (w_corr) begin
                        if (THRESH == 4'd1) begin
                            r_state  <= ISOLATED;
                            r_faulty <= replica_onehot(w_suspect);
                        end else begin
                            r_state   <= SUSPECT;
                            r_suspect <= w_suspect;
                            r_streak  <= 4'd1;
                        end
                    end
                end
                SUSPECT: begin
                    if (w_uncorr) begin
                        r_state   <= FAILED;
                        r_suspect <= REPLICA_NONE;
                        r_streak  <= '0;
                    end else if (w_corr && (w_suspect == r_suspect)) begin
                        if (r_streak + 4'd1 >= THRESH) begin
                            r_state   <= ISOLATED;
                            r_faulty  <= replica_onehot(w_suspect);
                            r_suspect <= REPLICA_NONE;
                            r_streak  <= '0;
                        end else begin
                            r_streak <= r_streak + 4'd1;
                        end
                    end else if (w_corr) begin
                        r_suspect <= w_suspect;
                        r_streak  <= 4'd1;
                    end else begin
                        r_state   <= NOMINAL;
                        r_suspect <= REPLICA_NONE;
                        r_streak  <= '0;
                    end
                end
                ISOLATED: begin
                    if (w_det) r_state <= FAILED;
                end
                default: ;
            endcase
        end
    end

    assign faulty_o = r_faulty;
    assign failed_o = (r_state == FAILED);
`else
    assign w_iso    = '0;
    assign faulty_o = '0;
    assign failed_o = 1'b0;
`endif

endmodule

// File: rtl/cv32e40p_tmr_voter_monitor.sv
// N_IN independent TMR voter channels with a shared registered valid.
// Replica isolation FSM is built only when CV32E40P_VOTER_ISOLATION_EN is defined.
module cv32e40p_tmr_voter_monitor #(
    parameter int unsigned LEN          = 32,
    parameter int unsigned N_IN         = 1,
    parameter int unsigned ERR_CNT_W    = 8,
    parameter int unsigned FAULT_THRESH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_i,
    input  logic                           clr_i,
    input  logic [N_IN-1:0][LEN-1:0]       in_1_i,
    input  logic [N_IN-1:0][LEN-1:0]       in_2_i,
    input  logic [N_IN-1:0][LEN-1:0]       in_3_i,
    output logic                           valid_o,
    output logic [N_IN-1:0][LEN-1:0]       voted_o,
    output logic [N_IN-1:0]                error_correct_o,
    output logic [N_IN-1:0]                error_detected_o,
    output logic [N_IN-1:0][2:0]           faulty_o,
    output logic [N_IN-1:0]                failed_o,
    output logic [N_IN-1:0][ERR_CNT_W-1:0] err_cnt_o
);

    logic r_valid;

    always_ff @(posedge clk) begin
        if (rst) r_valid <= 1'b0;
        else     r_valid <= valid_i;
    end

    assign valid_o = r_valid;

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_ch
        cv32e40p_voter_channel #(
            .LEN          (LEN),
            .ERR_CNT_W    (ERR_CNT_W),
            .FAULT_THRESH (FAULT_THRESH)
        ) u_channel (
            .clk              (clk),
            .rst              (rst),
            .valid_i          (valid_i),
            .clr_i            (clr_i),
            .in_1_i           (in_1_i[gi]),
            .in_2_i           (in_2_i[gi]),
            .in_3_i           (in_3_i[gi]),
            .voted_o          (voted_o[gi]),
            .error_correct_o  (error_correct_o[gi]),
            .error_detected_o (error_detected_o[gi]),
            .faulty_o         (faulty_o[gi]),
            .failed_o         (failed_o[gi]),
            .err_cnt_o        (err_cnt_o[gi])
        );
    end

endmodule

// File: tb/tb_cv32e40p_tmr_voter_monitor.sv
// Bench for cv32e40p_tmr_voter_monitor: directed scenarios plus random traffic against a
// replica-health model; expectations follow CV32E40P_VOTER_ISOLATION_EN when it is defined.
module tb_cv32e40p_tmr_voter_monitor;

    localparam int LEN          = 32;
    localparam int N_IN         = 2;
    localparam int ERR_CNT_W    = 2;
    localparam int FAULT_THRESH = 4;
    localparam int CNT_MAX      = (1 << ERR_CNT_W) - 1;

    logic                           clk = 1'b0;
    logic                           rst, valid_i, clr_i;
    logic [N_IN-1:0][LEN-1:0]       in_1_i, in_2_i, in_3_i;
    logic                           valid_o;
    logic [N_IN-1:0][LEN-1:0]       voted_o;
    logic [N_IN-1:0]                error_correct_o, error_detected_o, failed_o;
    logic [N_IN-1:0][2:0]           faulty_o;
    logic [N_IN-1:0][ERR_CNT_W-1:0] err_cnt_o;

    int total = 0;
    int bad   = 0;

    // Model: per-channel isolated replica (0 = none), current suspect and its run length.
    logic [31:0] m_voted[N_IN];
    bit          m_ec[N_IN], m_ed[N_IN], m_failed[N_IN];
    int          m_iso[N_IN], m_susp[N_IN], m_streak[N_IN], m_cnt[N_IN];
    bit          m_valid;
    int          fav[N_IN];

    always #5 clk = ~clk;

    cv32e40p_tmr_voter_monitor #(
        .LEN          (LEN),
        .N_IN         (N_IN),
        .ERR_CNT_W    (ERR_CNT_W),
        .FAULT_THRESH (FAULT_THRESH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .valid_i          (valid_i),
        .clr_i            (clr_i),
        .in_1_i           (in_1_i),
        .in_2_i           (in_2_i),
        .in_3_i           (in_3_i),
        .valid_o          (valid_o),
        .voted_o          (voted_o),
        .error_correct_o  (error_correct_o),
        .error_detected_o (error_detected_o),
        .faulty_o         (faulty_o),
        .failed_o         (failed_o),
        .err_cnt_o        (err_cnt_o)
    );

    function automatic logic [2:0] exp_faulty(input int ch);
        if (m_iso[ch] == 0) return 3'b000;
        return 3'(1 << (m_iso[ch] - 1));
    endfunction

    task automatic chan_step(input int ch);
        logic [31:0] w[3];
        logic [31:0] vote;
        bit          det, corr;
        int          outlier, p, q;
        w[0] = in_1_i[ch]; w[1] = in_2_i[ch]; w[2] = in_3_i[ch];
        vote = m_voted[ch]; det = 0; corr = 0; outlier = 0;
        if (valid_i) begin
            if (m_iso[ch] != 0) begin
                p = (m_iso[ch] == 1) ? 1 : 0;
                q = (m_iso[ch] == 3) ? 1 : 2;
                vote = w[p];
                det  = (w[p] != w[q]);
            end else begin
                if (w[0] == w[1] || w[0] == w[2]) vote = w[0];
                else if (w[1] == w[2])            vote = w[1];
                else                              vote = w[0];
                for (int r = 0; r < 3; r++) begin
                    if (w[(r+1)%3] == w[(r+2)%3] && w[r] != w[(r+1)%3]) outlier = r + 1;
                end
                det  = !(w[0] == w[1] && w[1] == w[2]);
                corr = (outlier != 0);
            end
        end
        m_voted[ch] = vote;
        m_ec[ch]    = corr;
        m_ed[ch]    = det;
        if (clr_i) begin
            m_cnt[ch] = 0; m_failed[ch] = 0; m_iso[ch] = 0; m_susp[ch] = 0; m_streak[ch] = 0;
        end else if (valid_i) begin
            if (det && m_cnt[ch] < CNT_MAX) m_cnt[ch]++;
`ifdef CV32E40P_VOTER_ISOLATION_EN
            if (!m_failed[ch]) begin
                if (det && !corr) begin
                    m_failed[ch] = 1; m_susp[ch] = 0; m_streak[ch] = 0;
                end else if (m_iso[ch] == 0) begin
                    if (corr) begin
                        if (m_susp[ch] == outlier) m_streak[ch]++;
                        else begin m_susp[ch] = outlier; m_streak[ch] = 1; end
                        if (m_streak[ch] >= FAULT_THRESH) begin
                            m_iso[ch] = outlier; m_susp[ch] = 0; m_streak[ch] = 0;
                        end
                    end else begin
                        m_susp[ch] = 0; m_streak[ch] = 0;
                    end
                end
            end
`endif
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_valid = 0;
            for (int ch = 0; ch < N_IN; ch++) begin
                m_voted[ch] = '0; m_ec[ch] = 0; m_ed[ch] = 0; m_failed[ch] = 0;
                m_iso[ch] = 0; m_susp[ch] = 0; m_streak[ch] = 0; m_cnt[ch] = 0;
            end
        end else begin
            m_valid = valid_i;
            for (int ch = 0; ch < N_IN; ch++) chan_step(ch);
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ch(input int ch, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        in_1_i[ch] = a; in_2_i[ch] = b; in_3_i[ch] = c;
    endtask

    task automatic test_reset();
        rst = 1; valid_i = 1; clr_i = 0;
        set_ch(0, 1, 2, 3); set_ch(1, 4, 4, 5);
        tick();
        rst = 0;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", valid_o); end
        total++; if (voted_o !== '0) begin bad++; $display("FAIL reset_voted got %h want 0", voted_o); end
        total++; if (error_detected_o !== '0 || error_correct_o !== '0) begin
            bad++; $display("FAIL reset_flags got det=%b cor=%b want 0", error_detected_o, error_correct_o); end
        total++; if (err_cnt_o !== '0) begin bad++; $display("FAIL reset_cnt got %h want 0", err_cnt_o); end
        total++; if (faulty_o !== '0 || failed_o !== '0) begin
            bad++; $display("FAIL reset_health got faulty=%b failed=%b want 0", faulty_o, failed_o); end
    endtask

    task automatic test_clean();
        valid_i = 1;
        set_ch(0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5); set_ch(1, 7, 7, 7);
        tick();
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL clean_valid got %b want 1", valid_o); end
        total++; if (voted_o[0] !== 32'hA5A5A5A5) begin bad++; $display("FAIL clean_voted got %h want a5a5a5a5", voted_o[0]); end
        total++; if (error_detected_o[0] !== 1'b0 || error_correct_o[0] !== 1'b0) begin
            bad++; $display("FAIL clean_flags got det=%b cor=%b want 0", error_detected_o[0], error_correct_o[0]); end
        total++; if (err_cnt_o[0] !== 2'd0) begin bad++; $display("FAIL clean_cnt got %0d want 0", err_cnt_o[0]); end
    endtask

    task automatic test_correctable();
        set_ch(0, 32'h1234, 32'hDEAD0000, 32'h1234);
        tick();
        total++; if (voted_o[0] !== 32'h1234) begin bad++; $display("FAIL corr_voted got %h want 1234", voted_o[0]); end
        total++; if (error_detected_o[0] !== 1'b1 || error_correct_o[0] !== 1'b1) begin
            bad++; $display("FAIL corr_flags got det=%b cor=%b want 1/1", error_detected_o[0], error_correct_o[0]); end
        total++; if (err_cnt_o[0] !== 2'd1) begin bad++; $display("FAIL corr_cnt got %0d want 1", err_cnt_o[0]); end
        total++; if (error_detected_o[1] !== 1'b0) begin bad++; $display("FAIL corr_ch1_det got %b want 0", error_detected_o[1]); end
    endtask

    task automatic test_isolation();
        logic [2:0] want_f;
        bit         want_det;
        clr_i = 1; valid_i = 0; tick(); clr_i = 0; valid_i = 1;
        for (int i = 0; i < 4; i++) begin
            set_ch(0, 7, 7, 32'h100 + i);
            tick();
            if (i == 2) begin
                total++; if (faulty_o[0] !== 3'b000) begin bad++; $display("FAIL iso_early got %b want 000", faulty_o[0]); end
            end
        end
`ifdef CV32E40P_VOTER_ISOLATION_EN
        want_f = 3'b100; want_det = 1'b0;
`else
        want_f = 3'b000; want_det = 1'b1;
`endif
        total++; if (faulty_o[0] !== want_f) begin bad++; $display("FAIL iso_faulty got %b want %b", faulty_o[0], want_f); end
        total++; if (err_cnt_o[0] !== 2'd3) begin bad++; $display("FAIL iso_cnt got %0d want 3", err_cnt_o[0]); end
        set_ch(0, 5, 5, 9);
        tick();
        total++; if (voted_o[0] !== 32'd5) begin bad++; $display("FAIL iso_voted got %h want 5", voted_o[0]); end
        total++; if (error_detected_o[0] !== want_det) begin
            bad++; $display("FAIL iso_det got %b want %b", error_detected_o[0], want_det); end
    endtask

    task automatic test_three_way();
        bit want_fail;
`ifdef CV32E40P_VOTER_ISOLATION_EN
        want_fail = 1'b1;
`else
        want_fail = 1'b0;
`endif
        clr_i = 1; valid_i = 0; tick(); clr_i = 0; valid_i = 1;
        set_ch(0, 1, 2, 3);
        tick();
        total++; if (voted_o[0] !== 32'd1) begin bad++; $display("FAIL tri_voted got %h want 1", voted_o[0]); end
        total++; if (error_detected_o[0] !== 1'b1 || error_correct_o[0] !== 1'b0) begin
            bad++; $display("FAIL tri_flags got det=%b cor=%b want 1/0", error_detected_o[0], error_correct_o[0]); end
        total++; if (failed_o[0] !== want_fail) begin bad++; $display("FAIL tri_failed got %b want %b", failed_o[0], want_fail); end
        for (int i = 0; i < 3; i++) begin set_ch(0, 9, 9, 9); tick(); end
        total++; if (failed_o[0] !== want_fail) begin bad++; $display("FAIL tri_sticky got %b want %b", failed_o[0], want_fail); end
        clr_i = 1; valid_i = 0; tick(); clr_i = 0;
        total++; if (failed_o[0] !== 1'b0) begin bad++; $display("FAIL tri_clr got %b want 0", failed_o[0]); end
        total++; if (error_detected_o[0] !== 1'b0) begin bad++; $display("FAIL tri_gapdet got %b want 0", error_detected_o[0]); end
    endtask

    task automatic test_saturation();
        int want[5];
        want = '{1, 2, 3, 3, 3};
        valid_i = 1;
        for (int i = 0; i < 5; i++) begin
            set_ch(0, 32'h10 + i, 32'h20 + i, 32'h30 + i);
            tick();
            total++; if (int'(err_cnt_o[0]) !== want[i]) begin
                bad++; $display("FAIL sat_cnt step %0d got %0d want %0d", i, err_cnt_o[0], want[i]); end
        end
        clr_i = 1; set_ch(0, 1, 2, 2);
        tick();
        clr_i = 0;
        total++; if (err_cnt_o[0] !== 2'd0) begin bad++; $display("FAIL sat_clr got %0d want 0", err_cnt_o[0]); end
        total++; if (error_detected_o[0] !== 1'b1 || voted_o[0] !== 32'd2) begin
            bad++; $display("FAIL sat_clrvote got det=%b voted=%h want 1/2", error_detected_o[0], voted_o[0]); end
    endtask

    task automatic test_channels();
        clr_i = 1; valid_i = 0; tick(); clr_i = 0; valid_i = 1;
        set_ch(0, 10, 99, 10); set_ch(1, 20, 20, 20); tick();
        set_ch(0, 10, 98, 10); set_ch(1, 21, 21, 21); tick();
        total++; if (error_detected_o[1] !== 1'b0 || err_cnt_o[1] !== 2'd0 || voted_o[1] !== 32'd21) begin
            bad++; $display("FAIL ch1_clean got det=%b cnt=%0d voted=%h want 0/0/21",
                            error_detected_o[1], err_cnt_o[1], voted_o[1]); end
        valid_i = 0; set_ch(0, 1, 2, 3); set_ch(1, 4, 5, 6);
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (voted_o[0] !== 32'd10 || voted_o[1] !== 32'd21) begin
                bad++; $display("FAIL gap_hold got %h %h want a 15", voted_o[0], voted_o[1]); end
            total++; if (error_detected_o !== '0 || err_cnt_o[0] !== 2'd2 || valid_o !== 1'b0) begin
                bad++; $display("FAIL gap_state got det=%b cnt=%0d valid=%b want 0/2/0",
                                error_detected_o, err_cnt_o[0], valid_o); end
        end
        rst = 1; valid_i = 1; tick(); rst = 0;
        total++; if (voted_o !== '0 || err_cnt_o !== '0 || faulty_o !== '0 || failed_o !== '0) begin
            bad++; $display("FAIL mid_rst got voted=%h cnt=%h faulty=%b failed=%b want 0",
                            voted_o, err_cnt_o, faulty_o, failed_o); end
        set_ch(0, 10, 97, 10); set_ch(1, 30, 30, 30); tick();
        set_ch(0, 10, 96, 10); tick();
        total++; if (faulty_o !== '0 || err_cnt_o[0] !== 2'd2 || err_cnt_o[1] !== 2'd0) begin
            bad++; $display("FAIL post_rst got faulty=%b cnt0=%0d cnt1=%0d want 0/2/0",
                            faulty_o, err_cnt_o[0], err_cnt_o[1]); end
    endtask

    task automatic test_random();
        logic [31:0] base, w[3];
        int          mode, r;
        rst = 1; tick(); rst = 0;
        fav[0] = 0; fav[1] = 2;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst     = ($urandom_range(0, 99) == 0);
            clr_i   = ($urandom_range(0, 39) == 0);
            valid_i = ($urandom_range(0, 4) != 0);
            for (int ch = 0; ch < N_IN; ch++) begin
                if ($urandom_range(0, 7) == 0) fav[ch] = $urandom_range(0, 2);
                base = $urandom;
                w[0] = base; w[1] = base; w[2] = base;
                mode = $urandom_range(0, 31);
                if (mode >= 10 && mode <= 27) w[fav[ch]] = base ^ (32'h1 << $urandom_range(0, 31));
                else if (mode == 28 || mode == 29) begin
                    r = $urandom_range(0, 2); w[r] = base ^ 32'h8000_0001;
                end else if (mode == 30) begin
                    w[1] = base ^ 32'h1; w[2] = base ^ 32'h2;
                end
                set_ch(ch, w[0], w[1], w[2]);
            end
            tick();
            total++; if (valid_o !== m_valid) begin bad++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, valid_o, m_valid); end
            for (int ch = 0; ch < N_IN; ch++) begin
                total++; if (voted_o[ch] !== m_voted[ch]) begin
                    bad++; $display("FAIL rnd_voted cyc %0d ch%0d got %h want %h", cyc, ch, voted_o[ch], m_voted[ch]); end
                total++; if (error_correct_o[ch] !== m_ec[ch] || error_detected_o[ch] !== m_ed[ch]) begin
                    bad++; $display("FAIL rnd_flags cyc %0d ch%0d got cor=%b det=%b want %b/%b", cyc, ch,
                                    error_correct_o[ch], error_detected_o[ch], m_ec[ch], m_ed[ch]); end
                total++; if (int'(err_cnt_o[ch]) !== m_cnt[ch]) begin
                    bad++; $display("FAIL rnd_cnt cyc %0d ch%0d got %0d want %0d", cyc, ch, err_cnt_o[ch], m_cnt[ch]); end
                total++; if (faulty_o[ch] !== exp_faulty(ch) || failed_o[ch] !== m_failed[ch]) begin
                    bad++; $display("FAIL rnd_health cyc %0d ch%0d got faulty=%b failed=%b want %b/%b", cyc, ch,
                                    faulty_o[ch], failed_o[ch], exp_faulty(ch), m_failed[ch]); end
            end
        end
        rst = 0; clr_i = 0; valid_i = 0;
    endtask

    initial begin
        rst = 1; valid_i = 0; clr_i = 0;
        in_1_i = '0; in_2_i = '0; in_3_i = '0;
        test_reset();
        test_clean();
        test_correctable();
        test_isolation();
        test_three_way();
        test_saturation();
        test_channels();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
